tea_decrypt_iter: RTL

Iterative TEA decryption engine. It is the inverse of the team's pipelined TEA encryptor.
- Takes a 64-bit ciphertext (v0, v1) and a 128-bit key (k0..k3).
- Executes one full decryption round per clock, then presents the recovered plaintext.
- Sits on the receive side of the link: it consumes ciphertext produced by the encryptor and hands plaintext downstream through a valid/ready handshake.

---
 rtl/tea_decrypt_iter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tea_decrypt_iter.sv
// Iterative TEA decryption engine.
// Accepts one ciphertext block and key through a valid/ready handshake, runs
// one decryption round per clock using the latched key, then holds the
// recovered plaintext with out_valid until the downstream accepts it.
module tea_decrypt_iter #(
   parameter int          ROUNDS = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] v0_in,
   input  logic [31:0] v1_in,
   input  logic [31:0] k0,
   input  logic [31:0] k1,
   input  logic [31:0] k2,
   input  logic [31:0] k3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] v0_out,
   output logic [31:0] v1_out
);

   localparam int CNT_W = $clog2(ROUNDS + 1);

   // Decryption walks the key schedule backwards, so sum starts at the value
   // the encryptor reached after its final round.
   localparam logic [31:0]      SUM_INIT   = DELTA * 32'(ROUNDS);
   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [31:0]      sum_q,       sum_d;
   logic [31:0]      v0_q,        v0_d;
   logic [31:0]      v1_q,        v1_d;
   logic [31:0]      k0_q,        k0_d;
   logic [31:0]      k1_q,        k1_d;
   logic [31:0]      k2_q,        k2_d;
   logic [31:0]      k3_q,        k3_d;
   logic [31:0]      v0_out_q,    v0_out_d;
   logic [31:0]      v1_out_q,    v1_out_d;
   logic             out_valid_q, out_valid_d;

   logic [31:0] v1_round;
   logic [31:0] v0_round;

   // TEA mixing term shared by both half-rounds.
   function automatic logic [31:0] tea_mix(
      input logic [31:0] v,
      input logic [31:0] s,
      input logic [31:0] ka,
      input logic [31:0] kb
   );
      return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
   endfunction

   // One decryption round: v1 is undone first, and its fresh value feeds v0.
   always_comb begin
      v1_round = v1_q - tea_mix(v0_q, sum_q, k2_q, k3_q);
      v0_round = v0_q - tea_mix(v1_round, sum_q, k0_q, k1_q);
   end

   // Next-state logic: handshake, round sequencing and result capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      v0_d        = v0_q;
      v1_d        = v1_q;
      k0_d        = k0_q;
      k1_d        = k1_q;
      k2_d        = k2_q;
      k3_d        = k3_q;
      v0_out_d    = v0_out_q;
      v1_out_d    = v1_out_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               v0_d    = v0_in;
               v1_d    = v1_in;
               k0_d    = k0;
               k1_d    = k1;
               k2_d    = k2;
               k3_d    = k3;
               sum_d   = SUM_INIT;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            v0_d  = v0_round;
            v1_d  = v1_round;
            sum_d = sum_q - DELTA;
            cnt_d = cnt_q + 1'b1;
            // The result registers are loaded straight from the final round so
            // they only ever change when a new plaintext is ready.
            if (cnt_q == LAST_ROUND) begin
               v0_out_d    = v0_round;
               v1_out_d    = v1_round;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State register; reset discards any block in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sum_q       <= '0;
         v0_q        <= '0;
         v1_q        <= '0;
         k0_q        <= '0;
         k1_q        <= '0;
         k2_q        <= '0;
         k3_q        <= '0;
         v0_out_q    <= '0;
         v1_out_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         v0_q        <= v0_d;
         v1_q        <= v1_d;
         k0_q        <= k0_d;
         k1_q        <= k1_d;
         k2_q        <= k2_d;
         k3_q        <= k3_d;
         v0_out_q    <= v0_out_d;
         v1_out_q    <= v1_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign v0_out    = v0_out_q;
   assign v1_out    = v1_out_q;

endmodule
